program_loader: RTL and testbench

- Writer side of the instruction-memory interface that fetch_unit reads; it loads a BeeF program image into instruction memory before execution starts.
- Accepts a framed byte stream over a valid/ready handshake: a magic byte, a 16-bit length, the payload and an optional checksum.
- Writes each payload byte to sequential instruction addresses starting at 0.
- Holds the processor core stalled until a complete, valid image has been loaded.

---
 rtl/program_loader_if.sv | 9 +
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake between an image source (master) and program_loader (slave).
interface program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Loads a framed image (MAGIC, len lo, len hi, payload) into instruction memory and holds the core until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR-of-payload byte (adds the CHECK state).
module program_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = 8'hBF
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   s_in,
  input  logic              rearm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  // state        | meaning
  // S_WAIT_MAGIC | hunting for MAGIC, other bytes dropped
  // S_LEN_LO     | expecting len[7:0]
  // S_LEN_HI     | expecting len[15:8], range-checked on arrival
  // S_DATA       | payload bytes written to imem
  // S_CHECK      | expecting XOR checksum (checksum builds only)
  // S_DONE       | image loaded, core released
  // S_ERROR      | frame rejected, core held
  typedef enum logic [2:0] {
    S_WAIT_MAGIC = 3'd0,
    S_LEN_LO     = 3'd1,
    S_LEN_HI     = 3'd2,
    S_DATA       = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK      = 3'd4,
`endif
    S_DONE       = 3'd5,
    S_ERROR      = 3'd6
  } state_t;

  localparam int          CNT_W = ADDR_W + 1;
  localparam int unsigned CAP   = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHECK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_fire;
  logic               w_ready_nx;
  logic               w_len_too_big;
  logic               w_len_zero;
  logic               w_last;
  logic [15:0]        w_len_full;
  logic [CNT_W-1:0]   w_count_inc;
  logic [7:0]         r_len_lo;
  logic [15:0]        r_len;
  logic [CNT_W-1:0]   r_count;
  logic               r_ready;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         r_chk;
`endif

  assign w_fire        = s_in.in_valid && r_ready;
  assign w_len_full    = {s_in.in_data, r_len_lo};
  assign w_len_too_big = 32'(w_len_full) > CAP;
  assign w_len_zero    = (w_len_full == 16'd0);
  assign w_count_inc   = r_count + CNT_W'(1);
  assign w_last        = (32'(w_count_inc) == 32'(r_len));
  assign w_ready_nx    = (w_state_nx != S_DONE) && (w_state_nx != S_ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_WAIT_MAGIC;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_WAIT_MAGIC: if (w_fire && s_in.in_data == MAGIC) w_state_nx = S_LEN_LO;
      S_LEN_LO:     if (w_fire) w_state_nx = S_LEN_HI;
      S_LEN_HI: begin
        if (w_fire) begin
          if (w_len_too_big)   w_state_nx = S_ERROR;
          else if (w_len_zero) w_state_nx = S_AFTER_DATA;
          else                 w_state_nx = S_DATA;
        end
      end
      S_DATA:       if (w_fire && w_last) w_state_nx = S_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:      if (w_fire) w_state_nx = (s_in.in_data == r_chk) ? S_DONE : S_ERROR;
`endif
      S_DONE, S_ERROR: if (rearm) w_state_nx = S_WAIT_MAGIC;
      default:      w_state_nx = S_WAIT_MAGIC;
    endcase
  end

  // in_ready is registered from the next state so it stays low through reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready  <= 1'b0;
      r_len_lo <= 8'd0;
      r_len    <= 16'd0;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      r_chk    <= 8'd0;
`endif
    end else begin
      r_ready <= w_ready_nx;
      r_we    <= 1'b0;
      if (r_state == S_LEN_LO && w_fire) r_len_lo <= s_in.in_data;
      if (r_state == S_LEN_HI && w_fire) r_len    <= w_len_full;
      if (r_state == S_DATA && w_fire) begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= s_in.in_data;
        r_count <= w_count_inc;
`ifdef LOADER_CHECKSUM_EN
        r_chk   <= r_chk ^ s_in.in_data;
`endif
      end
      if ((r_state == S_DONE || r_state == S_ERROR) && rearm) begin
        r_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_chk   <= 8'd0;
`endif
      end
    end
  end

  assign s_in.in_ready = r_ready;
  assign imem_we       = r_we;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  // done waits out a final write pulse so the last byte lands before the core is released
  assign load_done     = (r_state == S_DONE) && !r_we;
  assign cpu_hold      = !load_done;
  assign load_error    = (r_state == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized payloads against a frame-level model.
module tb_program_loader;
  localparam int         ADDR_W = 8;
  localparam int         CAP    = 1 << ADDR_W;
  localparam logic [7:0] MAGIC  = 8'hBF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rearm = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  program_loader_if bus();

  program_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (bus),
    .rearm      (rearm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_wr_seen = 0;
  int         exp_addr[$];
  int         exp_data[$];
  logic [7:0] tx_pl[$];
  bit         prev_fire = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write must echo the byte handshaken on the previous edge and match the model's next write.
  always @(negedge clk) begin
    if (!reset) begin
      prev_fire = 1'b0;
    end else begin
      if (imem_we === 1'b1) begin
        n_wr_seen++;
        chk(32'(prev_fire), 32'd1, "we_one_cycle_after_hs");
        chk(32'(imem_wdata), 32'(prev_data), "we_data_is_hs_byte");
        chk(32'(load_done), 32'd0, "done_not_during_we");
        if (exp_addr.size() > 0) begin
          chk(32'(imem_addr), exp_addr.pop_front(), "wr_addr");
          chk(32'(imem_wdata), exp_data.pop_front(), "wr_data");
        end
      end
      prev_fire = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      prev_data = bus.in_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) chk(32'(bus.in_ready), 32'd1, "send_timeout");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic fill_payload(input int len);
    tx_pl.delete();
    for (int i = 0; i < len; i++) tx_pl.push_back(8'($urandom));
  endtask

  // Model: a frame with len above capacity errors with no writes; otherwise every payload byte
  // lands at address i, and (checksum builds) a wrong trailing XOR byte turns done into error.
  task automatic load_frame(input int len, input bit bad_chk, input bit gaps);
    logic [15:0] l16;
    logic [7:0]  x;
    logic [7:0]  cbyte;
    bit          exp_err;
    int          nwr;
    l16 = 16'(len);
    x = 8'd0;
    n_wr_seen = 0;
    exp_addr.delete();
    exp_data.delete();
    exp_err = (len > CAP);
    nwr = exp_err ? 0 : len;
    for (int i = 0; i < nwr; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(int'(tx_pl[i]));
      x ^= tx_pl[i];
    end
    cbyte = bad_chk ? ((x == 8'h00) ? 8'hFF : 8'h00) : x;
`ifdef LOADER_CHECKSUM_EN
    if (!exp_err && bad_chk) exp_err = 1'b1;
`endif
    send_byte(MAGIC, gaps);
    send_byte(l16[7:0], gaps);
    send_byte(l16[15:8], gaps);
    if (len <= CAP) begin
      for (int i = 0; i < len; i++) send_byte(tx_pl[i], gaps);
`ifdef LOADER_CHECKSUM_EN
      send_byte(cbyte, gaps);
`endif
    end
    @(posedge clk); #1;
    chk(32'(n_wr_seen), 32'(nwr), "write_count");
    chk(32'(exp_addr.size()), 32'd0, "writes_pending");
    chk(32'(load_done), 32'(!exp_err), "load_done");
    chk(32'(load_error), 32'(exp_err), "load_error");
    chk(32'(cpu_hold), 32'(exp_err), "cpu_hold");
    chk(32'(bus.in_ready), 32'd0, "ready_after_frame");
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    @(posedge clk); #1;
    rearm = 1'b0;
    chk(32'(bus.in_ready), 32'd1, "rearm_ready");
    chk(32'(load_done), 32'd0, "rearm_done");
    chk(32'(load_error), 32'd0, "rearm_error");
    chk(32'(cpu_hold), 32'd1, "rearm_hold");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(32'(bus.in_ready), 32'd0, "rst_ready");
    chk(32'(imem_we), 32'd0, "rst_we");
    chk(32'(imem_addr), 32'd0, "rst_addr");
    chk(32'(imem_wdata), 32'd0, "rst_wdata");
    chk(32'(cpu_hold), 32'd1, "rst_hold");
    chk(32'(load_done), 32'd0, "rst_done");
    chk(32'(load_error), 32'd0, "rst_error");
    @(negedge clk);
    reset = 1'b1;
    #1 chk(32'(bus.in_ready), 32'd0, "ready_before_first_clk");
    @(posedge clk); #1;
    chk(32'(bus.in_ready), 32'd1, "ready_after_first_clk");

    tx_pl = {8'h2B, 8'h2E, 8'h3E};
    load_frame(3, 1'b0, 1'b0);
    do_rearm();
    load_frame(3, 1'b1, 1'b0);
    do_rearm();

    n_wr_seen = 0;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    @(posedge clk); #1;
    chk(32'(n_wr_seen), 32'd0, "garbage_no_write");
    chk(32'(bus.in_ready), 32'd1, "garbage_ready");
    chk(32'(load_done), 32'd0, "garbage_not_done");
    tx_pl.delete();
    load_frame(0, 1'b0, 1'b0);
    do_rearm();

    load_frame(CAP + 1, 1'b0, 1'b0);
    do_rearm();
    fill_payload(CAP);
    load_frame(CAP, 1'b0, 1'b0);
    do_rearm();

    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 40);
      fill_payload(len);
      load_frame(len, (k == 2), 1'b1);
      do_rearm();
    end

    fill_payload(5);
    n_wr_seen = 0;
    exp_addr.delete();
    exp_data.delete();
    exp_addr.push_back(0);
    exp_data.push_back(int'(tx_pl[0]));
    send_byte(MAGIC, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(tx_pl[0], 1'b0);
    send_byte(tx_pl[1], 1'b0);
    #2 reset = 1'b0;
    #1;
    chk(32'(imem_we), 32'd0, "async_rst_we");
    chk(32'(imem_addr), 32'd0, "async_rst_addr");
    chk(32'(imem_wdata), 32'd0, "async_rst_wdata");
    chk(32'(bus.in_ready), 32'd0, "async_rst_ready");
    chk(32'(cpu_hold), 32'd1, "async_rst_hold");
    chk(32'(load_done), 32'd0, "async_rst_done");
    chk(32'(load_error), 32'd0, "async_rst_error");
    chk(32'(n_wr_seen), 32'd1, "writes_before_rst");
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk(32'(bus.in_ready), 32'd1, "ready_after_rerelease");
    fill_payload(4);
    load_frame(4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
